uart_stim_tx: RTL
=================

# uart_stim_tx

Parametrised, synthesizable UART transmitter with an input FIFO, used as a serial stimulus source driving the SoC's terminal UART RX GPIO line in system simulation and on FPGA. It replaces fixed-rate, fixed-format byte-sending tasks with a clocked block that adds:
- a runtime baud divisor,
- optional parity,
- 1 or 2 stop bits,
- back-to-back frame streaming from a queue.

It sits between a host-side byte producer (bench sequencer or debug logic) and the single-bit `txd` line into the SoC.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame, legal 5..8, sent LSB first.
- `DIV_W`, 16: width of the baud divisor.
- `FIFO_DEPTH`, 16: byte queue depth, power of two, at least 2.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_div` in `DIV_W`: bit period is `cfg_div+1` clk cycles.
- `cfg_parity` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `cfg_stop2` in 1: 1 selects two stop bits, 0 selects one.
- `wr_valid` in 1: byte push request.
- `wr_ready` out 1: FIFO not full.
- `wr_data` in `DATA_W`: byte to queue.
- `txd` out 1: serial line, idle high.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- Push happens when `wr_valid && wr_ready`. There is no push-through when full; a push while full is ignored and does not corrupt state.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, latch `cfg_div`/`cfg_parity`/`cfg_stop2` for this frame, and go to START.
  - START: drive `txd=0` for one bit period, then go to DATA.
  - DATA: drive `shift[0]` for each bit period, shifting right, for `DATA_W` bits. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: drive a bit such that the XOR over data bits plus parity is 0 (even) or 1 (odd).
  - STOP: drive `txd=1` for 1 or 2 bit periods. Then pop the next byte if the FIFO is non-empty (going straight to START with no idle gap), else go to IDLE.
- Config changes take effect only at the next frame start. A frame in flight uses its latched config.
- Bit timer: counts down from the latched div to 0. At 0 the FSM advances its bit and reloads the timer. `cfg_div=0` gives 1 cycle per bit.
- Parity is computed from the popped byte at pop time, not at transmit time.
- Simultaneous push and pop on the same edge: occupancy is unchanged and both the data and the pointers stay correct. This holds when the FIFO is empty (the push is not visible to that pop) and when full (the push is refused, the pop proceeds).

## Timing
- Reset values: `txd=1`, `busy=0`, `wr_ready=1`, `fifo_level=0`, FSM in IDLE, FIFO emptied, timer 0.
- Reset asserted mid-frame: `txd` returns to 1 on the next edge and queued bytes are discarded. No partial frame resumes.
- Latency:
  - A push accepted at edge N into an empty FIFO with the FSM in IDLE gives `fifo_level=1` after N.
  - The pop occurs at N+1 and `txd` falls after edge N+1.
- The start bit lasts exactly `div+1` cycles, as does every subsequent bit.
- Frame length in cycles is `(div+1)*(1+DATA_W+P+S)`, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` is registered. It rises the cycle after the first accepted push and falls the cycle after the final stop bit completes with the FIFO empty.
- `wr_ready` is registered from the full flag. It deasserts the edge the FIFO reaches `FIFO_DEPTH` entries.
- Pointers wrap modulo `FIFO_DEPTH`. The full and empty conditions are distinguished by an extra pointer bit.

## Test plan
- Reset, then push 0x41 with `cfg_div=234`, no parity, 1 stop bit:
  - `txd` is low for 235 cycles;
  - then the bits 1,0,0,0,0,0,1,0 are sent, each 235 cycles;
  - then high;
  - total frame is 2350 cycles and `busy` drops afterwards.
- Push "A","B","C",0x0D,0x0A back-to-back with `cfg_div=3`:
  - five contiguous frames of 40 cycles each with no idle between stop and start;
  - a UART monitor decodes exactly 41 42 43 0D 0A.
- Parity and stop bits:
  - byte 0x07 with even parity gives parity bit 1;
  - with odd parity, parity bit 0;
  - with `cfg_stop2=1`, the line is high for 2 bit periods before the next start bit.
- FIFO full:
  - with `cfg_div=100`, push `FIFO_DEPTH+3` bytes holding `wr_valid` high;
  - `wr_ready` is 0 once the level reaches 16 (pop of the first byte frees one slot);
  - the extra pushes are not lost because the bench honours `wr_ready`;
  - the decoded sequence equals the pushed sequence in order.
- Config change mid-frame: switch `cfg_div` from 3 to 7 during the DATA state. The current frame stays at 4 cycles per bit and the next frame uses 8.
- Reset during the DATA state with 3 bytes queued: `txd=1`, `fifo_level=0` and `busy=0` the next cycle, and there is no further line activity.

Source files
------------

// File: rtl/uart_stim_tx.sv
// uart_stim_tx: UART transmitter fed from a byte FIFO, used as a serial stimulus source.
//   clk, rst        : single clock, synchronous active-high reset
//   cfg_div         : bit period is cfg_div+1 clocks (latched at frame start)
//   cfg_parity      : 00 none, 01 even, 10 odd, 11 none (latched at frame start)
//   cfg_stop2       : 1 = two stop bits (latched at frame start)
//   wr_valid/ready  : byte push handshake, wr_ready is a registered "not full"
//   wr_data         : byte to queue, sent LSB first
//   txd             : serial line, idle high
//   busy            : frame in progress or FIFO non-empty (registered)
//   fifo_level      : current FIFO occupancy
module uart_stim_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(DATA_W);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_d;
  logic              wr_ready_q, busy_q, txd_q, txd_d;
  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  timer_q, timer_d, div_q, div_d;
  logic [DATA_W-1:0] shift_q, shift_d, head;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic              push, pop, empty, tick;

  assign push  = wr_valid && wr_ready_q;
  // Pointers carry an extra bit so equal pointers mean empty, not full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem[rd_ptr_q[AW-1:0]];
  assign tick  = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    div_d     = div_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    pop       = 1'b0;

    if (state_q == StIdle) begin
      pop = !empty;
    end else if (!tick) begin
      timer_d = timer_q - 1'b1;
    end else begin
      timer_d = div_q;
      case (state_q)
        StStart: begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
        StData: begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            state_d   = par_en_q ? StParity : StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StParity: begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
        StStop: begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CntW'(1);
          end else if (!empty) begin
            pop = 1'b1;  // stream the next byte with no idle gap
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Frame start: config and parity are captured from the popped byte here.
    if (pop) begin
      state_d   = StStart;
      shift_d   = head;
      div_d     = cfg_div;
      timer_d   = cfg_div;
      stop2_d   = cfg_stop2;
      par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d = (^head) ^ (cfg_parity == 2'b10);
    end
  end

  always_comb begin
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_bit_d;
      default:  txd_d = 1'b1;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign level_d  = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ready_q <= (level_d != (AW+1)'(FIFO_DEPTH));
      busy_q     <= (state_d != StIdle) || (level_d != '0);
      txd_q      <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign txd        = txd_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;

endmodule
